// File: rtl/chacha20_stream_if.sv
// Word stream bundle between the datapath and chacha20_stream.
// The slave side is the cipher block; the master side drives plaintext in.
interface chacha20_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/chacha20_stream.sv
// ChaCha20 keystream XOR stage: fetches 512-bit blocks from the core
// one at a time and XORs them word by word onto a valid/ready stream.
module chacha20_stream #(
    parameter int BLOCK_WORDS = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [255:0]       key,
    input  logic [63:0]        nonce,
    input  logic [63:0]        init_index,
    chacha20_stream_if.slave   s,
    output logic               core_start,
    output logic [255:0]       core_key,
    output logic [63:0]        core_nonce,
    output logic [63:0]        core_index,
    input  logic               core_done,
    input  logic [511:0]       core_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        STREAM = 2'd3
    } state_t;

    localparam logic [3:0] LAST = 4'(BLOCK_WORDS - 1);

    state_t       state_q, state_d;
    logic         discard_q, discard_d;
    logic [3:0]   ptr_q, ptr_d;
    logic [63:0]  idx_q, idx_d;
    logic [255:0] key_q, key_d;
    logic [63:0]  nonce_q, nonce_d;
    logic [511:0] buf_q, buf_d;
    logic         start_q, start_d;
    logic         ov_q, ov_d;
    logic [31:0]  od_q, od_d;
    logic         in_rdy;
    logic [31:0]  ks_word;

    // Word k sits at bit 511-32k, i.e. {~k, 5'h1f} for 4-bit k.
    assign ks_word = buf_q[{~ptr_q, 5'h1f} -: 32];

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        key_d     = key_q;
        nonce_d   = nonce_q;
        buf_d     = buf_q;
        ov_d      = ov_q;
        od_d      = od_q;
        in_rdy    = 1'b0;

        if (ov_q && s.out_ready) begin
            ov_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
                if (load) begin
                    discard_d = 1'b1;
                end
            end
            WAIT: begin
                if (core_done) begin
                    // A load in the done cycle also makes this block stale.
                    if (discard_q || load) begin
                        discard_d = 1'b0;
                        state_d   = START;
                    end else begin
                        buf_d   = core_out;
                        ptr_d   = 4'd0;
                        idx_d   = idx_q + 64'd1;
                        state_d = STREAM;
                    end
                end else if (load) begin
                    discard_d = 1'b1;
                end
            end
            STREAM: begin
                if (load) begin
                    ptr_d   = 4'd0;
                    ov_d    = 1'b0;
                    state_d = START;
                end else begin
                    in_rdy = !ov_q || s.out_ready;
                    if (s.in_valid && in_rdy) begin
                        od_d  = s.in_data ^ ks_word;
                        ov_d  = 1'b1;
                        ptr_d = ptr_q + 4'd1;
                        if (ptr_q == LAST) begin
                            state_d = START;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            key_d   = key;
            nonce_d = nonce;
            idx_d   = init_index;
        end

        start_d = (state_d == START);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            ptr_q     <= 4'd0;
            idx_q     <= 64'd0;
            key_q     <= 256'd0;
            nonce_q   <= 64'd0;
            buf_q     <= 512'd0;
            start_q   <= 1'b0;
            ov_q      <= 1'b0;
            od_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            nonce_q   <= nonce_d;
            buf_q     <= buf_d;
            start_q   <= start_d;
            ov_q      <= ov_d;
            od_q      <= od_d;
        end
    end

    assign core_start  = start_q;
    assign core_key    = key_q;
    assign core_nonce  = nonce_q;
    assign core_index  = idx_q;
    assign s.in_ready  = in_rdy;
    assign s.out_valid = ov_q;
    assign s.out_data  = od_q;

endmodule

// File: tb/tb_chacha20_stream.sv
// Bench for chacha20_stream: behavioural ChaCha20 core model plus a
// keystream reference computed per word index from the block function.
module tb_chacha20_stream;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset_n, load_e, load_d, chain, tb_ready, spur;
    logic [255:0] key;
    logic [63:0]  nonce, init_index;

    chacha20_stream_if ei ();
    chacha20_stream_if di ();

    logic         e_start, d_start;
    logic [255:0] e_key, d_key;
    logic [63:0]  e_nonce, d_nonce, e_index, d_index;
    logic         e_done, d_done;
    logic         e_mdone = 1'b0;
    logic         d_mdone = 1'b0;
    logic [511:0] e_out = '0;
    logic [511:0] d_out = '0;
    int           e_cnt = 0;
    int           d_cnt = 0;

    assign e_done       = e_mdone | spur;
    assign d_done       = d_mdone;
    assign di.in_valid  = chain & ei.out_valid;
    assign di.in_data   = ei.out_data;
    assign ei.out_ready = chain ? di.in_ready : tb_ready;
    assign di.out_ready = tb_ready;

    chacha20_stream u_enc (
        .clock(clock), .reset_n(reset_n), .load(load_e),
        .key(key), .nonce(nonce), .init_index(init_index),
        .s(ei),
        .core_start(e_start), .core_key(e_key), .core_nonce(e_nonce),
        .core_index(e_index), .core_done(e_done), .core_out(e_out)
    );

    chacha20_stream u_dec (
        .clock(clock), .reset_n(reset_n), .load(load_d),
        .key(key), .nonce(nonce), .init_index(init_index),
        .s(di),
        .core_start(d_start), .core_key(d_key), .core_nonce(d_nonce),
        .core_index(d_index), .core_done(d_done), .core_out(d_out)
    );

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Original ChaCha20: 64-bit counter in words 12/13, nonce in 14/15,
    // output words serialized little-endian, packed first byte high.
    function automatic logic [511:0] chacha_block(input logic [255:0] k,
                                                  input logic [63:0] n,
                                                  input logic [63:0] idx);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e;
        s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = bswap(k[255-32*i -: 32]);
        s[12] = idx[31:0]; s[13] = idx[63:32];
        s[14] = n[31:0];   s[15] = n[63:32];
        x = s;
        for (int rr = 0; rr < 10; rr++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = bswap(x[i] + s[i]);
        return r;
    endfunction

    // Keystream word w of a stream that starts at block i0.
    function automatic logic [31:0] ks(input logic [255:0] k,
                                       input logic [63:0] n,
                                       input logic [63:0] i0, input int w);
        logic [511:0] t;
        t = chacha_block(k, n, i0 + 64'(w / 16)) << (32 * (w % 16));
        return t[511:480];
    endfunction

    // Core stand-ins: done is raised 21 cycles after start.
    always @(posedge clock) begin
        e_mdone <= 1'b0;
        d_mdone <= 1'b0;
        if (!reset_n) begin
            e_cnt <= 0;
            d_cnt <= 0;
        end else begin
            if (e_start) begin
                e_cnt <= 20;
                e_out <= chacha_block(e_key, e_nonce, e_index);
            end else if (e_cnt != 0) begin
                e_cnt <= e_cnt - 1;
                if (e_cnt == 1) e_mdone <= 1'b1;
            end
            if (d_start) begin
                d_cnt <= 20;
                d_out <= chacha_block(d_key, d_nonce, d_index);
            end else if (d_cnt != 0) begin
                d_cnt <= d_cnt - 1;
                if (d_cnt == 1) d_mdone <= 1'b1;
            end
        end
    end

    int vectors = 0;
    int errors  = 0;

    logic [31:0]  feed_q [$];
    logic [31:0]  pt [$];
    logic [31:0]  eo_q [$];
    logic [31:0]  do_q [$];
    logic [63:0]  s_idx [$];
    logic [255:0] s_key [$];
    int           s_dones [$];
    int           e_dones = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
        if (ei.in_valid && ei.in_ready) void'(feed_q.pop_front());
        if (ei.out_valid && ei.out_ready) eo_q.push_back(ei.out_data);
        if (di.out_valid && di.out_ready) do_q.push_back(di.out_data);
        if (e_start) begin
            chk("one_outstanding", 256'(e_cnt), 256'd0);
            s_idx.push_back(e_index);
            s_key.push_back(e_key);
            s_dones.push_back(e_dones);
        end
        if (e_mdone) e_dones++;
        @(posedge clock);
        #1;
        ei.in_valid = feed_q.size() > 0;
        ei.in_data  = (feed_q.size() > 0) ? feed_q[0] : 32'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        feed_q.delete(); pt.delete(); eo_q.delete(); do_q.delete();
        s_idx.delete(); s_key.delete(); s_dones.delete();
        e_dones = 0;
        cyc();
    endtask

    task automatic pulse_load(input bit le, input bit ld);
        load_e = le;
        load_d = ld;
        cyc();
        load_e = 1'b0;
        load_d = 1'b0;
    endtask

    task automatic feed(input int n, input bit zero);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = zero ? 32'h0 : $urandom;
            pt.push_back(w);
            feed_q.push_back(w);
        end
    endtask

    task automatic wait_q(input string tag, input bit dec, input int n,
                          input int budget);
        int c = 0;
        while (((dec ? do_q.size() : eo_q.size()) < n) && c < budget) begin
            cyc();
            c++;
        end
        chk(tag, 256'(dec ? do_q.size() : eo_q.size()), 256'(n));
    endtask

    task automatic chk_stream(input string tag, input logic [255:0] k,
                              input logic [63:0] n, input logic [63:0] i0,
                              input int from, input int cnt);
        for (int w = from; w < from + cnt; w++)
            chk(tag, 256'(eo_q[w]), 256'(pt[w] ^ ks(k, n, i0, w)));
    endtask

    task automatic rand_params();
        for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
        nonce      = {$urandom, $urandom};
        init_index = {$urandom, $urandom};
    endtask

    initial begin
        logic [255:0] ka, kb;
        logic [63:0]  ib;
        logic [31:0]  held;

        reset_n = 1'b0; load_e = 1'b0; load_d = 1'b0; chain = 1'b0;
        tb_ready = 1'b1; spur = 1'b0;
        key = '0; nonce = '0; init_index = '0;
        ei.in_valid = 1'b0; ei.in_data = 32'h0;
        cyc(); cyc();
        chk("rst_out_valid", 256'(ei.out_valid), 256'd0);
        chk("rst_in_ready", 256'(ei.in_ready), 256'd0);
        chk("rst_core_start", 256'(e_start), 256'd0);
        chk("rst_core_index", 256'(e_index), 256'd0);
        chk("rst_out_data", 256'(ei.out_data), 256'd0);
        chk("rst_core_key", e_key, 256'd0);
        do_reset();

        // Zero vector
        key = '0; nonce = '0; init_index = '0;
        pulse_load(1'b1, 1'b0);
        feed(16, 1'b1);
        wait_q("zv_count", 1'b0, 16, 200);
        chk("zv_w0", 256'(eo_q[0]), 256'h76b8e0ad);
        chk("zv_w1", 256'(eo_q[1]), 256'ha0f13d90);
        chk("zv_w2", 256'(eo_q[2]), 256'h405d6ae5);
        chk("zv_w3", 256'(eo_q[3]), 256'h5386bd28);
        chk("zv_w15", 256'(eo_q[15]), 256'hb2ee6586);
        chk_stream("zv_model", key, nonce, init_index, 4, 11);
        for (int i = 0; i < 10 && s_idx.size() < 2; i++) cyc();
        chk("zv_nstarts", 256'(s_idx.size()), 256'd2);
        chk("zv_idx0", 256'(s_idx[0]), 256'd0);
        chk("zv_idx1", 256'(s_idx[1]), 256'd1);

        // Round trip through two instances
        do_reset();
        chain = 1'b1;
        for (int i = 0; i < 32; i++) key[255-8*i -: 8] = 8'(i);
        nonce = 64'h0706050403020100;
        init_index = 64'd1;
        pulse_load(1'b1, 1'b1);
        feed(40, 1'b0);
        wait_q("rt_count", 1'b1, 40, 1000);
        for (int w = 0; w < 40; w++)
            chk("rt_word", 256'(do_q[w]), 256'(pt[w]));
        chk_stream("rt_ct", key, nonce, init_index, 0, 40);
        chk("rt_index", 256'(e_index), 256'd4);
        chain = 1'b0;

        // Backpressure mid-block
        do_reset();
        rand_params();
        pulse_load(1'b1, 1'b0);
        feed(16, 1'b0);
        wait_q("bp_pre", 1'b0, 5, 200);
        tb_ready = 1'b0;
        #1;
        held = ei.out_data;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 256'(ei.in_ready), 256'd0);
            chk("bp_valid", 256'(ei.out_valid), 256'd1);
            chk("bp_hold", 256'(ei.out_data), 256'(held));
            cyc();
        end
        chk("bp_no_dup", 256'(eo_q.size()), 256'd5);
        tb_ready = 1'b1;
        wait_q("bp_count", 1'b0, 16, 200);
        chk_stream("bp_word", key, nonce, init_index, 0, 16);

        // Index wrap
        do_reset();
        rand_params();
        init_index = '1;
        pulse_load(1'b1, 1'b0);
        feed(17, 1'b0);
        wait_q("wr_count", 1'b0, 17, 300);
        chk("wr_idx0", 256'(s_idx[0]), 256'(64'hFFFF_FFFF_FFFF_FFFF));
        chk("wr_idx1", 256'(s_idx[1]), 256'd0);
        chk_stream("wr_word", key, nonce, init_index, 0, 17);

        // Load during WAIT
        do_reset();
        rand_params();
        ka = key;
        pulse_load(1'b1, 1'b0);
        repeat (4) cyc();
        rand_params();
        kb = key;
        ib = init_index;
        pulse_load(1'b1, 1'b0);
        feed(16, 1'b0);
        wait_q("lw_count", 1'b0, 16, 300);
        chk("lw_nstarts", 256'(s_idx.size()), 256'd3);
        chk("lw_k0", s_key[0], ka);
        chk("lw_k1", s_key[1], kb);
        chk("lw_i1", 256'(s_idx[1]), 256'(ib));
        chk("lw_d1", 256'(s_dones[1]), 256'd1);
        chk("lw_d2", 256'(s_dones[2]), 256'd2);
        chk_stream("lw_word", kb, nonce, ib, 0, 16);

        // Reset mid-stream, then a spurious done in IDLE
        do_reset();
        rand_params();
        pulse_load(1'b1, 1'b0);
        feed(16, 1'b0);
        wait_q("rs_pre", 1'b0, 8, 200);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        #1;
        chk("rs_out_valid", 256'(ei.out_valid), 256'd0);
        chk("rs_in_ready", 256'(ei.in_ready), 256'd0);
        chk("rs_core_start", 256'(e_start), 256'd0);
        chk("rs_state", 256'(u_enc.state_q), 256'd0);
        spur = 1'b1;
        cyc();
        spur = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rs_idle_valid", 256'(ei.out_valid), 256'd0);
            chk("rs_idle_ready", 256'(ei.in_ready), 256'd0);
            chk("rs_idle_start", 256'(e_start), 256'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/chacha20_stream.md
# chacha20_stream

Keystream consumer and initiator for the `chacha20` block core. It latches a key, nonce and starting block index, then requests 512-bit keystream blocks from the core one at a time via its `start`/`done` handshake. It XORs each 32-bit word of a valid/ready input stream with the next keystream word and presents the result on a valid/ready output stream. The same block encrypts and decrypts; it sits between the core and the byte/word datapath.

## Interface
- `BLOCK_WORDS`, 16: keystream words per core block. Fixed to 16; the parameter exists only for local readability.
- `clock`  in  1  rising-edge clock for all state.
- `reset_n`  in  1  synchronous reset, active low.
- `load`  in  1  one-cycle pulse. Latches `key`, `nonce` and `init_index` and discards any buffered keystream.
- `key`  in  256  key; sampled only when `load`=1.
- `nonce`  in  64  nonce; sampled only when `load`=1.
- `init_index`  in  64  first block index (integer); sampled only when `load`=1.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when `in_valid && in_ready`.
- `in_data`  in  32  plaintext or ciphertext word.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `out_data`  out  32  `in_data ^ keystream word`.
- `core_start`  out  1  one-cycle request pulse to the core.
- `core_key`  out  256  registered copy of the latched key.
- `core_nonce`  out  64  registered copy of the latched nonce.
- `core_index`  out  64  index of the block being requested.
- `core_done`  in  1  one-cycle pulse; `core_out` is valid in this cycle.
- `core_out`  in  512  keystream block. Word k is `core_out[511-32k -: 32]`.

## Operation
- The state machine has four states: IDLE, START, WAIT, STREAM.
- **Reset** (`reset_n`=0 at a clock edge):
  - state ← IDLE; `discard` ← 0; `ptr` ← 0.
  - `core_index`, `core_key`, `core_nonce` ← 0.
  - `core_start`, `out_valid`, `out_data` ← 0. Reset overrides every other input.
- **IDLE:**
  - `in_ready`=0.
  - `load` latches the parameters (`core_index` ← `init_index`) and moves to START.
  - `core_done` is ignored.
- **START:**
  - `core_start` is registered high for exactly this one state-cycle, then the machine goes to WAIT.
- **WAIT:**
  - `in_ready`=0.
  - On `core_done` with `discard`=0: the 512-bit buffer ← `core_out`, `ptr` ← 0, `core_index` ← `core_index`+1, next state STREAM.
  - On `core_done` with `discard`=1: the block is dropped, `discard` ← 0, next state START (issues the request for the newly latched parameters).
- **STREAM:**
  - `in_ready` = `!out_valid || out_ready`.
  - On accept: `out_data` ← `in_data ^ buf[511-32*ptr -: 32]`, `out_valid` ← 1, `ptr` ← `ptr`+1.
  - When the accepted word has `ptr`=15, the next state is START. The next block is fetched only after the current one is exhausted.
- **Output register:**
  - `out_valid` clears when `out_ready`=1 and no new word is accepted in the same cycle.
  - `out_data` holds its value while `out_valid && !out_ready`.
- **Index arithmetic:** the index is 64-bit modulo 2^64. 0xFFFF_FFFF_FFFF_FFFF increments to 0 with no flag.
- **`load` during STREAM:** buffer discarded, `ptr` ← 0, `out_valid` ← 0 (any pending output word is dropped), parameters latched, next state START.
- **`load` during START or WAIT:** a core request is outstanding. Parameters are latched, `discard` ← 1, next state WAIT. A new `core_start` is never issued while a request is outstanding.
- **Simultaneous `load` and input accept:** `load` wins. `in_ready` is forced to 0 in the cycle `load`=1.
- **Spurious `core_done`:** ignored in IDLE, START and STREAM.

## Timing
- `load` at cycle t → START at t+1 → `core_start`=1 during t+1 → WAIT from t+2.
- `core_done` at cycle d → STREAM at d+1 → first `in_ready` at d+1.
- Input accepted at cycle a → `out_valid`/`out_data` at a+1.
- Throughput is 1 word/clock in STREAM. Per block, 16 words are followed by a gap of 2 cycles plus the core latency (the core raises `done` 21 cycles after `start` at ROUNDS=20).
- `core_index`, `core_key` and `core_nonce` are stable from the `core_start` cycle through the matching `core_done`.

## Test plan
- **Zero vector:**
  - Stimulus: key=0, nonce=0, `init_index`=0, `load`, then 16 zero input words with `out_ready`=1.
  - Required: `out_data` sequence starts 32'h76b8e0ad, 32'ha0f13d90, 32'h405d6ae5, 32'h5386bd28, and word 15 = 32'hb2ee6586. `core_start` pulses twice: index 0, then index 1 after word 15.
- **Round trip:**
  - Stimulus: 40 random words with key=00..1f, nonce=0x0706050403020100, index=1; feed the output back through a second instance with the same parameters.
  - Required: the second instance's output equals the original input. `core_index` reaches 4 after 3 blocks.
- **Backpressure:**
  - Stimulus: hold `out_ready`=0 for 5 cycles mid-block.
  - Required: `in_ready`=0 after one accepted word; `out_data` is stable; no word is lost or duplicated; `ptr` is unchanged.
- **Index wrap:**
  - Stimulus: `init_index`=64'hFFFF_FFFF_FFFF_FFFF; consume 17 words.
  - Required: second `core_start` has `core_index`=0.
- **Load during WAIT:**
  - Stimulus: `load` with key A, then `load` with key B 5 cycles later.
  - Required: exactly one extra `core_start` (with key B), issued only after the first `core_done`. The first block never appears on `out_data`; output equals key B keystream.
- **Reset mid-STREAM:**
  - Stimulus: `reset_n`=0 for one cycle after word 7.
  - Required: the next cycle shows `out_valid`=0, `in_ready`=0, `core_start`=0, state IDLE. A subsequent `core_done` is ignored.
